clk_enable_gen: RTL
===================

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 LOCK_WAIT, 4096: number of consecutive clk_sys cycles with synchronized lock high before sys_reset releases; legal range 2..65535.
REQ-002 clk_sys  in  1  42.954545 MHz system clock from the PLL; the only clock in the block.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pll_locked  in  1  PLL lock indication; treated as asynchronous to clk_sys.
REQ-005 turbo  in  1  1 selects double CPU rate (24-cycle CPU period); 0 selects normal rate (48-cycle CPU period).
REQ-006 sys_reset  out  1  core-wide synchronous reset, active-high.
REQ-007 ce_vdg  out  1  one-cycle enable at clk_sys/12 (3.579545 MHz).
REQ-008 ce_q_rise, ce_e_rise, ce_q_fall, ce_e_fall  out  1 each  one-cycle CPU phase-edge enables.
REQ-009 cpu_q, cpu_e  out  1 each  registered 6809E Q/E quadrature levels.

Function
REQ-010 pll_locked SHALL pass through a 2-flop synchronizer (locked_s) before any other use.
REQ-011 16-bit lock_cnt: clears when locked_s=0; increments when locked_s=1 and lock_cnt<LOCK_WAIT; saturates at LOCK_WAIT.
REQ-012 sys_reset SHALL be registered and high whenever reset=1 or lock_cnt<LOCK_WAIT.
REQ-013 Lock timing: with pll_locked held high from cycle 0, sys_reset is first low at cycle LOCK_WAIT+3.
REQ-014 Lock loss: any locked_s drop SHALL clear lock_cnt and reassert sys_reset 4 cycles after pll_locked falls; a full LOCK_WAIT requalification SHALL follow.
REQ-015 While sys_reset=1: vdg_cnt=0, phase=0, all ce_* =0, cpu_q=cpu_e=0, turbo_act=0.
REQ-016 vdg_cnt (mod 12) increments each cycle with sys_reset=0; ce_vdg=1 exactly when vdg_cnt=11.
REQ-017 phase (6-bit) increments each cycle with sys_reset=0 and wraps to 0 after phase=P-1, where P=48 if turbo_act=0 and P=24 if turbo_act=1.
REQ-018 Normal-rate combinational strobes: ce_q_rise at phase 0, ce_e_rise at 12, ce_q_fall at 24, ce_e_fall at 36.
REQ-019 Turbo-rate combinational strobes: ce_q_rise at phase 0, ce_e_rise at 6, ce_q_fall at 12, ce_e_fall at 18.
REQ-020 Strobes SHALL be gated by ~sys_reset; at most one CPU strobe is high per cycle.
REQ-021 cpu_q/cpu_e SHALL be set or cleared on the cycle after their respective strobe (one-cycle registered latency).
REQ-022 turbo_act SHALL load turbo only on the last phase of a CPU period (phase=P-1), so a rate change takes effect at the next phase 0; turbo toggling mid-period SHALL produce no runt Q/E pulse and no missing or duplicated strobe.
REQ-023 The first cycle with sys_reset=0 is phase 0: ce_q_rise=1 on that cycle; the first ce_vdg occurs 11 cycles later.
REQ-024 ce_vdg SHALL be independent of turbo; at normal rate, exactly 4 ce_vdg pulses occur per CPU period.

Reset
REQ-025 reset=1 SHALL force sys_reset=1 on the next edge and clear lock_cnt, phase, vdg_cnt, turbo_act, cpu_q, cpu_e and the synchronizer flops; all ce_* read 0 throughout.
REQ-026 Releasing reset with pll_locked high SHALL restart full lock qualification (sys_reset low at LOCK_WAIT+3 cycles after release).

Verification
REQ-027 LOCK_WAIT=16; pll_locked rises at cycle 0 -> sys_reset low at cycle 19; ce_q_rise at cycle 19; ce_vdg at cycle 30.
REQ-028 Normal run, 480 cycles after release -> 40 ce_vdg, 10 of each CPU strobe; cpu_q high for cycles 1..24 and cpu_e high for cycles 13..36 of each period (relative to ce_q_rise).
REQ-029 turbo=1 asserted at phase 20 -> current period completes at 48 cycles; next period is 24 cycles with E rising at phase 6; turbo=0 at phase 5 of a turbo period -> that period still ends at 24 cycles.
REQ-030 pll_locked deasserted for 1 cycle mid-run -> sys_reset high within 4 cycles, all ce_* =0, Q/E low; re-release LOCK_WAIT+3 cycles after lock returns, starting at phase 0.
REQ-031 reset pulsed at phase 30 with lock stable -> sys_reset high on next edge, outputs zero, release after 19 cycles (LOCK_WAIT=16).
REQ-032 Randomized turbo toggling over 10^5 cycles -> checker confirms Q/E high/low widths are always 24 (normal) or 12 (turbo) cycles and the strobe order is Q rise, E rise, Q fall, E fall.

Source files
------------

// File: rtl/clk_enable_gen.sv
// Clock-enable generator for the 6809E/VDG core.
// Qualifies PLL lock into sys_reset and derives the VDG and CPU Q/E phase enables.
module clk_enable_gen #(
    parameter int unsigned LOCK_WAIT = 4096
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pll_locked,
    input  logic turbo,
    output logic sys_reset,
    output logic ce_vdg,
    output logic ce_q_rise,
    output logic ce_e_rise,
    output logic ce_q_fall,
    output logic ce_e_fall,
    output logic cpu_q,
    output logic cpu_e
);

    localparam logic [15:0] LOCK_WAIT_W = 16'(LOCK_WAIT);

    logic        lock_meta;
    logic        locked_s;
    logic [15:0] lock_cnt;
    logic        sys_reset_nx;
    logic        hold;
    logic [3:0]  vdg_cnt;
    logic [5:0]  phase;
    logic [5:0]  phase_last;
    logic        turbo_act;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || !locked_s)
            lock_cnt <= '0;
        else if (lock_cnt < LOCK_WAIT_W)
            lock_cnt <= lock_cnt + 16'd1;
    end

    always_comb begin
        sys_reset_nx = reset | (lock_cnt < LOCK_WAIT_W);
        // Clearing on the incoming reset level too keeps Q/E low on the very
        // cycle sys_reset rises, while phase still starts at 0 on release.
        hold         = sys_reset | sys_reset_nx;
        phase_last   = turbo_act ? 6'd23 : 6'd47;
    end

    always_ff @(posedge clk_sys) begin
        sys_reset <= sys_reset_nx;
    end

    always_ff @(posedge clk_sys) begin
        if (hold) begin
            vdg_cnt   <= '0;
            phase     <= '0;
            turbo_act <= 1'b0;
        end else begin
            vdg_cnt <= (vdg_cnt == 4'd11) ? 4'd0 : vdg_cnt + 4'd1;
            if (phase == phase_last) begin
                phase     <= '0;
                turbo_act <= turbo;
            end else begin
                phase <= phase + 6'd1;
            end
        end
    end

    always_comb begin
        ce_vdg    = 1'b0;
        ce_q_rise = 1'b0;
        ce_e_rise = 1'b0;
        ce_q_fall = 1'b0;
        ce_e_fall = 1'b0;
        if (!sys_reset) begin
            ce_vdg = (vdg_cnt == 4'd11);
            if (turbo_act) begin
                ce_q_rise = (phase == 6'd0);
                ce_e_rise = (phase == 6'd6);
                ce_q_fall = (phase == 6'd12);
                ce_e_fall = (phase == 6'd18);
            end else begin
                ce_q_rise = (phase == 6'd0);
                ce_e_rise = (phase == 6'd12);
                ce_q_fall = (phase == 6'd24);
                ce_e_fall = (phase == 6'd36);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (hold) begin
            cpu_q <= 1'b0;
            cpu_e <= 1'b0;
        end else begin
            if (ce_q_rise)
                cpu_q <= 1'b1;
            else if (ce_q_fall)
                cpu_q <= 1'b0;
            if (ce_e_rise)
                cpu_e <= 1'b1;
            else if (ce_e_fall)
                cpu_e <= 1'b0;
        end
    end

endmodule
